// File: rtl/slicer_pkg.sv
// Shared constants and helpers for the LLR hard-decision slicer.
package slicer_pkg;

  localparam int FRAME_COUNT_W   = 16;
  localparam int SINGLE_SIGN_BIT = 31;

  function automatic int sym_cnt_width(input int symbols);
    return (symbols > 1) ? $clog2(symbols) : 1;
  endfunction

endpackage

// File: rtl/llr_sign_magnitude.sv
// One LLR lane: hard decision (strictly positive -> 1) and sign-cleared magnitude.
module llr_sign_magnitude #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] word,
  output logic            decision,
  output logic [BITS-1:0] magnitude
);

  // +0 and -0 both decide 0: only a clear sign with a nonzero body counts as positive.
  assign decision  = ~word[BITS-1] & (|word[BITS-2:0]);
  assign magnitude = {1'b0, word[BITS-2:0]};

endmodule

// File: rtl/stream_llr_slicer.sv
// Collects a frame of LLR symbols into a shadow register, then hands decisions,
// minimum magnitude and a frame count to a valid/ready output stage.
module stream_llr_slicer
  import slicer_pkg::*;
#(
  parameter int BITS            = 32,
  parameter     PRECISION       = "SINGLE",
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 17
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  input  logic [BITS-1:0]                    LLR_D [BITS_PER_SYMBOL],
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS-1:0] decisions,
  output logic [BITS-1:0]                    min_mag,
  output logic [FRAME_COUNT_W-1:0]           frame_count,
  output logic                               overflow
);

  localparam int                SYM_W    = sym_cnt_width(SYMBOLS);
  localparam int                DEC_W    = BITS_PER_SYMBOL * SYMBOLS;
  localparam logic [SYM_W-1:0]  LAST_SYM = SYM_W'(SYMBOLS - 1);

  generate
    if (PRECISION != "SINGLE" || BITS != SINGLE_SIGN_BIT + 1) begin : g_bad_precision
      $error("stream_llr_slicer: only SINGLE precision with 32-bit words is supported");
    end
  endgenerate

  logic [BITS_PER_SYMBOL-1:0] lane_dec;
  logic [BITS-1:0]            lane_mag [BITS_PER_SYMBOL];
  logic [BITS-1:0]            sym_min;
  logic [SYM_W-1:0]           sym_cnt;
  logic [DEC_W-1:0]           shadow_dec;
  logic [DEC_W-1:0]           shadow_dec_nxt;
  logic [BITS-1:0]            shadow_min;
  logic                       frame_done;

  generate
    for (genvar l = 0; l < BITS_PER_SYMBOL; l++) begin : g_lane
      llr_sign_magnitude #(.BITS(BITS)) u_lane (
        .word      (LLR_D[l]),
        .decision  (lane_dec[l]),
        .magnitude (lane_mag[l])
      );
    end
  endgenerate

  always_comb begin
    sym_min = lane_mag[0];
    for (int l = 1; l < BITS_PER_SYMBOL; l++) begin
      if (lane_mag[l] < sym_min) sym_min = lane_mag[l];
    end
  end

  always_comb begin
    shadow_dec_nxt = shadow_dec;
    for (int s = 0; s < SYMBOLS; s++) begin
      if (sym_cnt == SYM_W'(s)) shadow_dec_nxt[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = lane_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_cnt     <= '0;
      shadow_dec  <= '0;
      shadow_min  <= '0;
      frame_done  <= 1'b0;
      out_valid   <= 1'b0;
      decisions   <= '0;
      min_mag     <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow   <= 1'b0;
      frame_done <= in_valid && (sym_cnt == LAST_SYM);
      if (in_valid) begin
        shadow_dec <= shadow_dec_nxt;
        // Symbol 0 reseeds the minimum so the previous frame cannot leak in.
        shadow_min <= (sym_cnt == '0 || sym_min < shadow_min) ? sym_min : shadow_min;
        sym_cnt    <= (sym_cnt == LAST_SYM) ? '0 : sym_cnt + SYM_W'(1);
      end
      // Shadow is read one cycle after the last symbol; symbol 0 of the next
      // frame may land in the shadow on this same edge without corrupting it.
      if (frame_done) begin
        if (!out_valid || out_ready) begin
          out_valid   <= 1'b1;
          decisions   <= shadow_dec;
          min_mag     <= shadow_min;
          frame_count <= frame_count + FRAME_COUNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_llr_slicer.sv
// Directed bench for stream_llr_slicer with hand-computed expected frames.
module tb_stream_llr_slicer;

  localparam int BITS = 32;
  localparam int BPS  = 2;
  localparam int SYMS = 17;

  localparam logic [31:0] P1    = 32'h3F80_0000;
  localparam logic [31:0] M1    = 32'hBF80_0000;
  localparam logic [33:0] DEC_A = 34'h1_5555_5555;
  localparam logic [33:0] DEC_B = 34'h2_AAAA_AAAA;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [BITS-1:0]       LLR_D [BPS];
  logic                  out_valid;
  logic [BPS*SYMS-1:0]   decisions;
  logic [BITS-1:0]       min_mag;
  logic [15:0]           frame_count;
  logic                  overflow;

  logic [31:0] lane0_v [SYMS];
  logic [31:0] lane1_v [SYMS];

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  int n_ovf    = 0;
  int xfer0, ovf0;
  logic [15:0] fc_q  [$];
  logic [33:0] dec_q [$];

  always #5 clk = ~clk;

  stream_llr_slicer #(
    .BITS(BITS), .PRECISION("SINGLE"), .BITS_PER_SYMBOL(BPS), .SYMBOLS(SYMS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .LLR_D(LLR_D),
    .out_valid(out_valid), .out_ready(out_ready), .decisions(decisions),
    .min_mag(min_mag), .frame_count(frame_count), .overflow(overflow)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        n_xfer++;
        fc_q.push_back(frame_count);
        dec_q.push_back(decisions);
      end
      if (overflow) n_ovf++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int s = 0; s < SYMS; s++) begin
      lane0_v[s] = a;
      lane1_v[s] = b;
    end
  endtask

  // gaps: an idle cycle carrying junk data precedes every symbol
  task automatic send_syms(input int n, input bit gaps);
    for (int s = 0; s < n; s++) begin
      if (gaps) begin
        in_valid = 1'b0;
        LLR_D[0] = 32'h0000_0000;
        LLR_D[1] = 32'h0000_0000;
        step();
      end
      in_valid = 1'b1;
      LLR_D[0] = lane0_v[s];
      LLR_D[1] = lane1_v[s];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  initial begin
    LLR_D[0] = '0;
    LLR_D[1] = '0;

    // reset state, with in_valid asserted to show it is ignored
    reset_n  = 1'b0;
    in_valid = 1'b1;
    LLR_D[0] = P1;
    LLR_D[1] = M1;
    repeat (2) step();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dec", decisions, 0);
    chk("rst_min", min_mag, 0);
    chk("rst_fc", frame_count, 0);

    // contiguous +1/-1 frame
    out_ready = 1'b1;
    fill(P1, M1);
    send_syms(SYMS, 1'b0);
    chk("lat_not_yet", out_valid, 0);
    step();
    chk("f1_valid", out_valid, 1);
    chk("f1_dec", decisions, DEC_A);
    chk("f1_min", min_mag, P1);
    chk("f1_fc", frame_count, 1);
    step();
    chk("f1_drop", out_valid, 0);

    // same frame with in_valid toggled
    send_syms(SYMS, 1'b1);
    step();
    chk("gap_valid", out_valid, 1);
    chk("gap_dec", decisions, DEC_A);
    chk("gap_min", min_mag, P1);
    chk("gap_fc", frame_count, 2);

    // -0 and 0.25 on lane 0
    fill(P1, M1);
    lane0_v[5] = 32'h8000_0000;
    lane0_v[9] = 32'h3E80_0000;
    send_syms(SYMS, 1'b0);
    step();
    chk("neg0_dec", decisions, 34'h1_5555_5155);
    chk("neg0_min", min_mag, 32'h0000_0000);
    chk("neg0_fc", frame_count, 3);

    // minimum reseeded: previous frame's zero must not survive
    fill(P1, M1);
    lane1_v[3] = 32'hBE80_0000;
    send_syms(SYMS, 1'b0);
    step();
    chk("seed_dec", decisions, DEC_A);
    chk("seed_min", min_mag, 32'h3E80_0000);

    // two frames back-to-back
    do_reset();
    fc_q.delete();
    dec_q.delete();
    xfer0 = n_xfer;
    ovf0  = n_ovf;
    out_ready = 1'b1;
    fill(P1, M1);
    send_syms(SYMS, 1'b0);
    fill(M1, P1);
    send_syms(SYMS, 1'b0);
    repeat (3) step();
    chk("b2b_xfers", n_xfer - xfer0, 2);
    chk("b2b_fc0", (fc_q.size() > 0) ? fc_q[0] : 16'hDEAD, 1);
    chk("b2b_fc1", (fc_q.size() > 1) ? fc_q[1] : 16'hDEAD, 2);
    chk("b2b_dec0", (dec_q.size() > 0) ? dec_q[0] : '0, DEC_A);
    chk("b2b_dec1", (dec_q.size() > 1) ? dec_q[1] : '0, DEC_B);
    chk("b2b_ovf", n_ovf - ovf0, 0);

    // output stalled while a second frame completes
    do_reset();
    ovf0 = n_ovf;
    out_ready = 1'b0;
    fill(P1, M1);
    send_syms(SYMS, 1'b0);
    step();
    chk("stall_valid", out_valid, 1);
    chk("stall_dec", decisions, DEC_A);
    fill(M1, 32'h3E80_0000);
    send_syms(SYMS, 1'b0);
    chk("ovf_pre", overflow, 0);
    step();
    chk("ovf_pulse", overflow, 1);
    step();
    chk("ovf_clear", overflow, 0);
    chk("ovf_count", n_ovf - ovf0, 1);
    chk("held_valid", out_valid, 1);
    chk("held_dec", decisions, DEC_A);
    chk("held_min", min_mag, P1);
    chk("held_fc", frame_count, 1);
    out_ready = 1'b1;
    step();
    chk("stall_release", out_valid, 0);

    // reset in mid-frame, with in_valid high during the reset cycle
    fill(M1, P1);
    lane0_v[2] = 32'h3E80_0000;
    send_syms(8, 1'b0);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    LLR_D[0] = M1;
    LLR_D[1] = P1;
    step();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_fc", frame_count, 0);
    dec_q.delete();
    xfer0 = n_xfer;
    fill(P1, M1);
    send_syms(16, 1'b0);
    step();
    chk("mid_rst_early", out_valid, 0);
    send_syms(1, 1'b0);
    repeat (3) step();
    chk("mid_rst_xfers", n_xfer - xfer0, 1);
    chk("mid_rst_dec", (dec_q.size() > 0) ? dec_q[0] : '0, DEC_A);
    chk("mid_rst_min", min_mag, P1);
    chk("mid_rst_fc2", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
